// File: rtl/toggle_pulse_gen.sv
// Debounces a raw push-button into a clean one-cycle T pulse per accepted press,
// with a debounced level output and a wrapping press counter. Optional macro: AUTO_REPEAT_EN.
module toggle_pulse_gen #(
    parameter int DB_LIMIT      = 4,
    parameter int DB_W          = 16,
    parameter int CNT_W         = 8,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn_in,
    output logic             o_t,
    output logic             o_btn_level,
    output logic [CNT_W-1:0] o_press_cnt
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARM_PRESS = 2'd1,
        S_HELD      = 2'd2,
        S_ARM_REL   = 2'd3
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LIMIT - 1);

    // Elaboration-time parameter sanity.
    if (DB_LIMIT < 2) begin : g_bad_db_limit
        $error("toggle_pulse_gen: DB_LIMIT must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("toggle_pulse_gen: REPEAT_CYCLES must be >= 1");
    end

    logic             r_sync0;
    logic             r_sync1;
    state_t           r_state;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_t;
    logic             r_btn_level;
    logic [CNT_W-1:0] r_press_cnt;
    logic             w_btn_s;

    assign w_btn_s = r_sync1;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] r_rpt_cnt;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync0     <= 1'b0;
            r_sync1     <= 1'b0;
            r_state     <= S_IDLE;
            r_db_cnt    <= '0;
            r_t         <= 1'b0;
            r_btn_level <= 1'b0;
            r_press_cnt <= '0;
`ifdef AUTO_REPEAT_EN
            r_rpt_cnt   <= '0;
`endif
        end else begin
            r_sync0 <= i_btn_in;
            r_sync1 <= r_sync0;
            r_t     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_btn_s) begin
                        r_state  <= S_ARM_PRESS;
                        r_db_cnt <= '0;
                    end
                end
                S_ARM_PRESS: begin
                    if (!w_btn_s) begin
                        r_state  <= S_IDLE;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state     <= S_HELD;
                        r_db_cnt    <= '0;
                        r_t         <= 1'b1;
                        r_btn_level <= 1'b1;
                        r_press_cnt <= r_press_cnt + CNT_W'(1);
`ifdef AUTO_REPEAT_EN
                        r_rpt_cnt   <= '0;
`endif
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
                S_HELD: begin
                    // Leaving for ARM_REL wins over a coincident repeat tick.
                    if (!w_btn_s) begin
                        r_state  <= S_ARM_REL;
                        r_db_cnt <= '0;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (r_rpt_cnt == RPT_LAST) begin
                        r_t         <= 1'b1;
                        r_press_cnt <= r_press_cnt + CNT_W'(1);
                        r_rpt_cnt   <= '0;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                    end
`endif
                end
                S_ARM_REL: begin
                    // Repeat counter is frozen here and resumes on return to HELD.
                    if (w_btn_s) begin
                        r_state  <= S_HELD;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state     <= S_IDLE;
                        r_db_cnt    <= '0;
                        r_btn_level <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_db_cnt <= '0;
                end
            endcase
        end
    end

    assign o_t         = r_t;
    assign o_btn_level = r_btn_level;
    assign o_press_cnt = r_press_cnt;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench for toggle_pulse_gen: per-cycle vector table plus hand sequences
// for mid-press bounce, counter wrap, reset at debounce completion and long hold.
module tb_toggle_pulse_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       t;
    logic       lvl;
    logic [7:0] cnt;

    int total  = 0;
    int bad    = 0;
    int t_seen = 0;

    always #5 clk = ~clk;

    toggle_pulse_gen #(
        .DB_LIMIT(4), .DB_W(16), .CNT_W(8), .REPEAT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn_in(btn),
        .o_t(t), .o_btn_level(lvl), .o_press_cnt(cnt)
    );

    typedef struct {
        logic       rst;
        logic       btn;
        logic       t;
        logic       lvl;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic b, input logic et,
                                input logic el, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.btn = b; v.t = et; v.lvl = el; v.cnt = ec;
        tbl.push_back(v);
    endfunction

    // One clock: drive on negedge, sample 1 time unit after the posedge.
    task automatic step(input logic r, input logic b);
        @(negedge clk);
        rst = r;
        btn = b;
        @(posedge clk);
        #1;
        if (t === 1'b1) t_seen++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int base;
        int pos[$];
        logic lvl_dropped;

        // Reset for two cycles.
        add(1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0);
        // Clean press held 20 cycles: T only after edge k+6.
        for (int i = 0; i < 20; i++)
            add(0, 1, (i == 6), (i >= 6), (i >= 6) ? 8'd1 : 8'd0);
        // Release: level drops after edge j+6.
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, (i < 6), 8'd1);
        // 3-cycle glitch: rejected.
        for (int i = 0; i < 12; i++)
            add(0, (i < 3), 0, 0, 8'd1);
        // Shortest accepted press: 5 high samples.
        for (int i = 0; i < 16; i++)
            add(0, (i < 5), (i == 6), (i >= 6 && i <= 10), (i >= 6) ? 8'd2 : 8'd1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].btn);
            chk($sformatf("vec%0d t", i),   t,   tbl[i].t);
            chk($sformatf("vec%0d lvl", i), lvl, tbl[i].lvl);
            chk($sformatf("vec%0d cnt", i), cnt, tbl[i].cnt);
        end

        // Release bounce while HELD: no new pulse, level stays high.
        for (int i = 0; i < 10; i++) step(0, 1);
        chk("s4 press cnt", cnt, 3);
        base = t_seen;
        lvl_dropped = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(0, 0);
            if (lvl !== 1'b1) lvl_dropped = 1'b1;
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 1);
            if (lvl !== 1'b1) lvl_dropped = 1'b1;
        end
        chk("s4 no extra T", t_seen - base, 0);
        chk("s4 level dropped", lvl_dropped, 0);
        chk("s4 cnt kept", cnt, 3);
        for (int i = 0; i < 10; i++) step(0, 0);
        chk("s4 released lvl", lvl, 0);

        // 256 clean presses wrap the counter.
        step(1, 0);
        step(1, 0);
        chk("s5 reset cnt", cnt, 0);
        t_seen = 0;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 8; i++) step(0, 1);
            for (int i = 0; i < 8; i++) step(0, 0);
            if (p == 254) chk("s5 cnt 255", cnt, 255);
        end
        chk("s5 cnt wrapped", cnt, 0);
        chk("s5 T count", t_seen, 256);

        // Reset on the edge where debounce would complete.
        step(1, 0);
        step(1, 0);
        t_seen = 0;
        for (int i = 0; i < 6; i++) step(0, 1);
        step(1, 1);
        chk("s6 rst T", t, 0);
        chk("s6 rst cnt", cnt, 0);
        chk("s6 rst lvl", lvl, 0);
        chk("s6 no pulse", t_seen, 0);
        for (int i = 0; i < 8; i++) step(0, 0);

        // 30-cycle hold.
        step(1, 0);
        step(1, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, (i < 30));
            if (t === 1'b1) pos.push_back(i);
        end
`ifdef AUTO_REPEAT_EN
        chk("s6 repeat count", pos.size(), 4);
        chk("s6 repeat cnt", cnt, 4);
        if (pos.size() == 4) begin
            chk("s6 rpt pos0", pos[0], 6);
            chk("s6 rpt pos1", pos[1], 14);
            chk("s6 rpt pos2", pos[2], 22);
            chk("s6 rpt pos3", pos[3], 30);
        end
`else
        chk("s6 hold count", pos.size(), 1);
        chk("s6 hold cnt", cnt, 1);
        if (pos.size() == 1) chk("s6 hold pos", pos[0], 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
